fibonacci_index: RTL and testbench
==================================

Name: fibonacci_index

Overview:
- Inverse companion to the team's Fibonacci generator. The generator maps an index n to F(n); this block maps a value v back to an index.
- It returns the smallest n (0..31) with F(n) >= v, and flags whether v is exactly a Fibonacci number.
- Iterative, one Fibonacci step per clock. It uses the same start/ready/done handshake as the generator, so the two blocks can be chained for round-trip checks.
- Definition: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).

Parameters:
- N, 16: width of the value input. Legal range N >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- start  input  1  request; sampled only while ready=1.
- value  input  N  value to search for; sampled in the same cycle start is accepted.
- ready  output  1  high while in IDLE.
- done  output  1  one-cycle pulse; result is valid.
- index  output  5  smallest n with F(n) >= value, saturating at 31.
- found  output  1  1 when F(index) == value.
- sat  output  1  1 when F(31) < value, i.e. no index <= 31 reaches value.

Behaviour:
- States: IDLE, SEARCH, DONE. Use one-hot or binary encoding, implementer's choice.
- Reset (rst=0, asynchronous):
  - state <= IDLE.
  - index, found and sat registers <= 0; all internal registers cleared.
  - Outputs during reset: ready=1, done=0.
  - Reset mid-SEARCH or in DONE aborts immediately. No done pulse follows, and results read 0.
- Outputs by state:
  - ready=1 only in IDLE; done=1 only in DONE. Both are decoded from the state register, not registered separately.
- IDLE:
  - When start=1: latch v_reg <= value, t0 <= 0, t1 <= 1, n <= 1; go to SEARCH.
  - Results of the previous run stay unchanged until that same edge; on it, found and sat clear to 0.
  - When start=0: stay in IDLE.
- SEARCH: evaluate one priority-ordered check per cycle.
  1. v_reg == 0: index <= 0, found <= 1; go to DONE.
  2. t1 >= v_reg: index <= n, found <= (t1 == v_reg); go to DONE.
  3. n == 31: index <= 31, found <= 0, sat <= 1; go to DONE.
  4. Otherwise: t0 <= t1, t1 <= t0 + t1, n <= n + 1; stay in SEARCH.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Handshake:
  - start is ignored outside IDLE; inputs are not captured and no error is raised.
  - start held high continuously re-launches on each IDLE cycle: back-to-back throughput is one request per (k+2) cycles.
- Latency:
  - For a result index k >= 1, SEARCH lasts k cycles; for v=0 it lasts 1 cycle.
  - done is high in the (k+1)th cycle after the accepting edge. For v=0 this is the 2nd cycle.
- Width rules:
  - t0 and t1 are max(N+1, 21) bits wide, so t0 + t1 never wraps before a termination check fires.
  - n is 5 bits and never increments past 31.
  - value is unsigned; the compare is full-width unsigned.
- Result hold: index, found and sat hold their values from the DONE edge until the next accepted start or reset.

Test Plan:
- Reset then value=0, start pulse (N=16) -> done pulse 2 cycles after accept; index=0, found=1, sat=0. ready=1 during reset and again after DONE.
- value=1 -> done 2 cycles after accept; index=1, found=1. Then value=13 -> 7 SEARCH cycles, done at cycle 8; index=7, found=1.
- value=14 -> index=8 (F(8)=21), found=0. Then value=65535 (N=16) -> index=25 (F(25)=75025), found=0, sat=0.
- N=24, value=16777215 -> index=31, found=0, sat=1; done 32 cycles after accept.
- Start asserted during SEARCH with a different value -> ignored; the original result is unchanged. Start held high across DONE -> new run accepted on the first IDLE cycle.
- rst asserted mid-SEARCH (value=13, 3 cycles in) -> state is IDLE and index/found/sat read 0 immediately, without waiting for a clock edge. No done pulse follows. The next start with value=21 -> index=8, found=1.

Source files
------------

// File: rtl/fibonacci_index.sv
// rtl/fibonacci_index.sv - smallest n (0..31) with F(n) >= value, one Fibonacci step per clock
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   start  request, sampled only while ready=1
//   value  N-bit unsigned search value, captured with an accepted start
//   ready  high while idle
//   done   one-cycle pulse, results valid
//   index  smallest n with F(n) >= value, saturating at 31
//   found  F(index) == value
//   sat    F(31) < value
module fibonacci_index #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] value,
  output logic         ready,
  output logic         done,
  output logic [4:0]   index,
  output logic         found,
  output logic         sat
);

  // Wide enough for F(31) = 1346269 (21 bits) and for any N-bit value plus
  // one carry, so t0 + t1 cannot wrap before a termination check fires.
  localparam int TW = (N + 1 > 21) ? (N + 1) : 21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    v_reg;
  logic [TW-1:0]   t0;
  logic [TW-1:0]   t1;
  logic [4:0]      n;
  logic [TW-1:0]   v_ext;

  // t1 always holds F(n) while searching.
  assign v_ext = TW'(v_reg);

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      v_reg <= '0;
      t0    <= '0;
      t1    <= '0;
      n     <= '0;
      index <= '0;
      found <= 1'b0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v_reg <= value;
            t0    <= '0;
            t1    <= TW'(1);
            n     <= 5'd1;
            // index keeps the previous result until a new one is written.
            found <= 1'b0;
            sat   <= 1'b0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (v_reg == '0) begin
            index <= 5'd0;
            found <= 1'b1;
            state <= DONE;
          end else if (t1 >= v_ext) begin
            index <= n;
            found <= (t1 == v_ext);
            state <= DONE;
          end else if (n == 5'd31) begin
            index <= 5'd31;
            found <= 1'b0;
            sat   <= 1'b1;
            state <= DONE;
          end else begin
            t0 <= t1;
            t1 <= t0 + t1;
            n  <= n + 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index.sv
// tb/tb_fibonacci_index.sv - self-checking bench for fibonacci_index
module tb_fibonacci_index;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        ready, done, found, sat;
  logic [4:0]  index;

  logic        start24 = 1'b0;
  logic [23:0] value24 = '0;
  logic        ready24, done24, found24, sat24;
  logic [4:0]  index24;

  int vectors = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fibonacci_index #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .ready(ready), .done(done), .index(index), .found(found), .sat(sat)
  );

  fibonacci_index #(.N(24)) dut24 (
    .clk(clk), .rst(rst), .start(start24), .value(value24),
    .ready(ready24), .done(done24), .index(index24), .found(found24), .sat(sat24)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] idx;
    logic       fnd;
    logic       st;
    logic [5:0] lat;
  } res_t;

  // Reference: walk F(0), F(1), ... and stop at the first term >= v.
  function automatic res_t fib_ref(input logic [31:0] v);
    longint a, b, t;
    res_t r;
    r = '0;
    if (v == 0) begin
      r.fnd = 1'b1;
      r.lat = 6'd1;
      return r;
    end
    a = 0;
    b = 1;
    for (int k = 1; k <= 31; k++) begin
      if (b >= longint'(v)) begin
        r.idx = k[4:0];
        r.fnd = (b == longint'(v));
        r.lat = k[5:0];
        return r;
      end
      t = a + b;
      a = b;
      b = t;
    end
    r.idx = 5'd31;
    r.st  = 1'b1;
    r.lat = 6'd31;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the N=16 instance: phase 0 idle, 1 search, 2 done.
  int         m_ph = 0;
  int         m_left = 0;
  logic [4:0] m_idx = '0;
  logic       m_fnd = 1'b0;
  logic       m_sat = 1'b0;
  res_t       m_pend = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph  <= 0;
      m_idx <= '0;
      m_fnd <= 1'b0;
      m_sat <= 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_pend <= fib_ref({16'd0, value});
          m_left <= int'(fib_ref({16'd0, value}).lat);
          m_fnd  <= 1'b0;
          m_sat  <= 1'b0;
          m_ph   <= 1;
        end
        1: begin
          if (m_left == 1) begin
            m_idx <= m_pend.idx;
            m_fnd <= m_pend.fnd;
            m_sat <= m_pend.st;
            m_ph  <= 2;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", {31'd0, ready}, {31'd0, m_ph == 0});
      chk("model_done",  {31'd0, done},  {31'd0, m_ph == 2});
      chk("model_index", {27'd0, index}, {27'd0, m_idx});
      chk("model_found", {31'd0, found}, {31'd0, m_fnd});
      chk("model_sat",   {31'd0, sat},   {31'd0, m_sat});
    end
  end

  task automatic launch16(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (cycle 1).
  task automatic wait16(output int c);
    c = 1;
    while (done !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run16(input logic [15:0] v, input int lat, input int ei, input int ef, input int es);
    int c;
    launch16(v);
    wait16(c);
    chk("latency", c, lat);
    chk("index", {27'd0, index}, ei);
    chk("found", {31'd0, found}, ef);
    chk("sat", {31'd0, sat}, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int pulses;
    res_t r;

    // Pin the reference against hand-computed values.
    r = fib_ref(32'd13);       chk("pin13_idx", {27'd0, r.idx}, 7);  chk("pin13_fnd", {31'd0, r.fnd}, 1);
    r = fib_ref(32'd14);       chk("pin14_idx", {27'd0, r.idx}, 8);  chk("pin14_fnd", {31'd0, r.fnd}, 0);
    r = fib_ref(32'd65535);    chk("pin65535_idx", {27'd0, r.idx}, 25);
    r = fib_ref(32'd16777215); chk("pin_sat_idx", {27'd0, r.idx}, 31); chk("pin_sat_st", {31'd0, r.st}, 1);
    r = fib_ref(32'd0);        chk("pin0_lat", {26'd0, r.lat}, 1);

    #2 rst = 1'b0;
    #1;
    chk("reset_ready", {31'd0, ready}, 1);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_index", {27'd0, index}, 0);
    chk("reset_found", {31'd0, found}, 0);
    chk("reset_sat", {31'd0, sat}, 0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run16(16'd0, 2, 0, 1, 0);
    @(negedge clk);
    chk("ready_after_done", {31'd0, ready}, 1);

    run16(16'd1, 2, 1, 1, 0);
    run16(16'd13, 8, 7, 1, 0);
    run16(16'd14, 9, 8, 0, 0);
    run16(16'd65535, 26, 25, 0, 0);

    // Saturation on the wide instance.
    @(negedge clk);
    start24 = 1'b1;
    value24 = 24'd16777215;
    @(negedge clk);
    start24 = 1'b0;
    c = 1;
    while (done24 !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("sat24_latency", c, 32);
    chk("sat24_index", {27'd0, index24}, 31);
    chk("sat24_found", {31'd0, found24}, 0);
    chk("sat24_sat", {31'd0, sat24}, 1);

    // start during SEARCH must be ignored.
    launch16(16'd13);
    start = 1'b1;
    value = 16'd3;
    c = 1;
    while (done !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
      if (c == 4) start = 1'b0;
    end
    chk("ignore_latency", c, 8);
    chk("ignore_index", {27'd0, index}, 7);
    chk("ignore_found", {31'd0, found}, 1);

    // start held high across DONE relaunches on the first IDLE cycle.
    @(negedge clk);
    start = 1'b1;
    value = 16'd5;
    @(negedge clk);
    wait16(c);
    chk("held1_latency", c, 6);
    chk("held1_index", {27'd0, index}, 5);
    value = 16'd8;
    @(negedge clk);
    chk("held_idle_ready", {31'd0, ready}, 1);
    @(negedge clk);
    start = 1'b0;
    wait16(c);
    chk("held2_latency", c, 7);
    chk("held2_index", {27'd0, index}, 6);
    chk("held2_found", {31'd0, found}, 1);

    // Asynchronous reset three cycles into a search.
    launch16(16'd13);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready}, 1);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_index", {27'd0, index}, 0);
    chk("abort_found", {31'd0, found}, 0);
    chk("abort_sat", {31'd0, sat}, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run16(16'd21, 9, 8, 1, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
